// File: rtl/bp_me_dev_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_dev_arbiter_if
// Description : Bundle of the requester-side, device-side and status signals
//               of bp_me_dev_arbiter. The arbiter uses the slave modport; the
//               environment driving it uses the master modport.
//               timeout_o exists only when BP_ME_DEV_ARBITER_TIMEOUT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_me_dev_arbiter_if #(
    parameter int num_req_p         = 4,
    parameter int header_width_p    = 128,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
);
    localparam int CNT_W = $clog2(max_outstanding_p + 1);

    // requester command side
    logic [num_req_p*header_width_p-1:0] req_header_i;
    logic [num_req_p*data_width_p-1:0]   req_critical_i;
    logic [num_req_p-1:0]                req_v_i;
    logic [num_req_p-1:0]                req_ready_and_o;
    // device command side
    logic [header_width_p-1:0]           dev_cmd_header_o;
    logic [data_width_p-1:0]             dev_cmd_critical_o;
    logic                                dev_cmd_v_o;
    logic                                dev_cmd_ready_and_i;
    // device response side
    logic [header_width_p-1:0]           dev_resp_header_i;
    logic [data_width_p-1:0]             dev_resp_critical_i;
    logic                                dev_resp_v_i;
    logic                                dev_resp_ready_and_o;
    // requester response side
    logic [header_width_p-1:0]           resp_header_o;
    logic [data_width_p-1:0]             resp_critical_o;
    logic [num_req_p-1:0]                resp_v_o;
    logic [num_req_p-1:0]                resp_ready_and_i;
    // status
    logic [CNT_W-1:0]                    outstanding_o;
    logic                                error_o;
`ifdef BP_ME_DEV_ARBITER_TIMEOUT_EN
    logic                                timeout_o;
`endif

    modport slave (
`ifdef BP_ME_DEV_ARBITER_TIMEOUT_EN
        output timeout_o,
`endif
        input  req_header_i, req_critical_i, req_v_i,
        output req_ready_and_o,
        output dev_cmd_header_o, dev_cmd_critical_o, dev_cmd_v_o,
        input  dev_cmd_ready_and_i,
        input  dev_resp_header_i, dev_resp_critical_i, dev_resp_v_i,
        output dev_resp_ready_and_o,
        output resp_header_o, resp_critical_o, resp_v_o,
        input  resp_ready_and_i,
        output outstanding_o, error_o
    );

    modport master (
`ifdef BP_ME_DEV_ARBITER_TIMEOUT_EN
        input  timeout_o,
`endif
        output req_header_i, req_critical_i, req_v_i,
        input  req_ready_and_o,
        input  dev_cmd_header_o, dev_cmd_critical_o, dev_cmd_v_o,
        output dev_cmd_ready_and_i,
        output dev_resp_header_i, dev_resp_critical_i, dev_resp_v_i,
        input  dev_resp_ready_and_o,
        input  resp_header_o, resp_critical_o, resp_v_o,
        output resp_ready_and_i,
        input  outstanding_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_me_dev_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_dev_arbiter
// Description : Round-robin arbiter sharing one BedRock memory device among
//               num_req_p requesters. Granted requester IDs are kept in an
//               in-order tag FIFO so device responses are routed back to the
//               requester at the FIFO head with zero added latency.
//               Optional watchdog: define BP_ME_DEV_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_dev_arbiter #(
    parameter int num_req_p         = 4,
    parameter int header_width_p    = 128,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
`ifdef BP_ME_DEV_ARBITER_TIMEOUT_EN
  , parameter int timeout_cycles_p  = 1024
`endif
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_me_dev_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(num_req_p);
    localparam int PTR_W = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int CNT_W = $clog2(max_outstanding_p + 1);

    // state
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] tag_mem_q [max_outstanding_p];
    logic [IDX_W-1:0] tag_mem_d [max_outstanding_p];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    // combinational
    logic [IDX_W-1:0]          w_grant;
    logic                      w_any_v;
    logic [IDX_W:0]            w_sum;
    logic [header_width_p-1:0] w_cmd_header;
    logic [data_width_p-1:0]   w_cmd_critical;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_cmd_hs;
    logic                      w_resp_hs;
    logic [IDX_W-1:0]          w_head;
    logic [num_req_p-1:0]      w_req_ready;
    logic [num_req_p-1:0]      w_resp_v;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(max_outstanding_p - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (count_q == CNT_W'(max_outstanding_p));
    assign w_empty = (count_q == '0);
    assign w_head  = tag_mem_q[rd_ptr_q];

    // Round-robin grant: the lowest offset from rr_q with a valid request wins,
    // so scan offsets from high to low and let the last hit stand.
    always_comb begin
        w_grant = '0;
        w_any_v = 1'b0;
        w_sum   = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            w_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(num_req_p)) begin
                w_sum = w_sum - (IDX_W+1)'(num_req_p);
            end
            if (bus.req_v_i[w_sum[IDX_W-1:0]]) begin
                w_grant = w_sum[IDX_W-1:0];
                w_any_v = 1'b1;
            end
        end
    end

    // Command payload mux and per-requester ready/response-valid decode.
    always_comb begin
        w_cmd_header   = '0;
        w_cmd_critical = '0;
        w_req_ready    = '0;
        w_resp_v       = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (w_grant == IDX_W'(k)) begin
                w_cmd_header   = bus.req_header_i[k*header_width_p +: header_width_p];
                w_cmd_critical = bus.req_critical_i[k*data_width_p +: data_width_p];
                w_req_ready[k] = ~reset_i & w_any_v & ~w_full & bus.dev_cmd_ready_and_i;
            end
            if (w_head == IDX_W'(k)) begin
                w_resp_v[k] = ~reset_i & ~w_empty & bus.dev_resp_v_i;
            end
        end
    end

    assign w_cmd_hs  = ~reset_i & w_any_v & ~w_full & bus.dev_cmd_ready_and_i;
    assign w_resp_hs = ~reset_i & ~w_empty & bus.dev_resp_v_i & bus.resp_ready_and_i[w_head];

    assign bus.dev_cmd_header_o   = w_cmd_header;
    assign bus.dev_cmd_critical_o = w_cmd_critical;
    assign bus.dev_cmd_v_o        = ~reset_i & w_any_v & ~w_full;
    assign bus.req_ready_and_o    = w_req_ready;
    assign bus.resp_header_o      = bus.dev_resp_header_i;
    assign bus.resp_critical_o    = bus.dev_resp_critical_i;
    assign bus.resp_v_o           = w_resp_v;
    // With nothing outstanding a stray response is swallowed so the network
    // never backs up behind it.
    assign bus.dev_resp_ready_and_o = ~reset_i &
        (w_empty ? bus.dev_resp_v_i : bus.resp_ready_and_i[w_head]);
    assign bus.outstanding_o      = count_q;
    assign bus.error_o            = error_q;

    // Next-state: tag push/pop, pointer advance, occupancy and sticky error.
    always_comb begin
        rr_d      = rr_q;
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        error_d   = error_q | (bus.dev_resp_v_i & w_empty);
        if (w_cmd_hs) begin
            tag_mem_d[wr_ptr_q] = w_grant;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            rr_d                = (w_grant == IDX_W'(num_req_p - 1)) ? '0 : w_grant + IDX_W'(1);
        end
        if (w_resp_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({w_cmd_hs, w_resp_hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared immediately on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            for (int i = 0; i < max_outstanding_p; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            error_q   <= error_d;
            tag_mem_q <= tag_mem_d;
        end
    end

`ifdef BP_ME_DEV_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout_cycles_p + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Watchdog: counts stalled cycles with work outstanding, saturates at the
    // limit; the flag is raised on the edge where the count reaches it.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (w_empty || w_resp_hs) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(timeout_cycles_p)) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (wd_d == WD_W'(timeout_cycles_p)) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    // No watchdog: a silent device simply holds its commands outstanding.
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_dev_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_me_dev_arbiter
// Description : Scoreboard bench for bp_me_dev_arbiter. A driver applies
//               directed and random stimulus, steps a queue-based reference
//               model and queues the expected responses; an independent
//               monitor pops and compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_dev_arbiter;
    localparam int N   = 4;
    localparam int HW  = 128;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_me_dev_arbiter_if #(.num_req_p(N), .header_width_p(HW),
                           .data_width_p(DW), .max_outstanding_p(MAX)) bus ();

    bp_me_dev_arbiter #(.num_req_p(N), .header_width_p(HW),
                        .data_width_p(DW), .max_outstanding_p(MAX)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic         cmd_v;
        logic [N-1:0] req_rdy;
        logic [N-1:0] resp_v;
        logic         dresp_rdy;
        int           outst;
        logic         err;
    } stat_t;
    typedef struct {
        logic [HW-1:0] hdr;
        logic [DW-1:0] crit;
    } pay_t;
    typedef struct {
        logic [N-1:0]  onehot;
        logic [HW-1:0] hdr;
        logic [DW-1:0] crit;
    } rsp_t;

    stat_t stat_q[$];
    pay_t  cmd_q[$];
    rsp_t  rsp_q[$];

    // reference model: rotating priority origin, in-flight requester IDs, error
    int m_rr = 0;
    int m_tq[$];
    bit m_err = 0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's view of that cycle.
    task automatic step(input bit r, input logic [N-1:0] v, input bit dready,
                        input bit rv, input logic [N-1:0] rrdy);
        logic [HW-1:0] hdr [N];
        logic [DW-1:0] crit [N];
        logic [HW-1:0] rhdr;
        logic [DW-1:0] rcrit;
        stat_t s;
        pay_t  p;
        rsp_t  q;
        int    g;
        int    head;
        bit    any, full, accept, pop;
        @(negedge clk);
        rst = r;
        for (int k = 0; k < N; k++) begin
            hdr[k]  = {$urandom, $urandom, $urandom, $urandom};
            crit[k] = {$urandom, $urandom};
            bus.req_header_i[k*HW +: HW] = hdr[k];
            bus.req_critical_i[k*DW +: DW] = crit[k];
        end
        rhdr  = {$urandom, $urandom, $urandom, $urandom};
        rcrit = {$urandom, $urandom};
        bus.req_v_i             = v;
        bus.dev_cmd_ready_and_i = dready;
        bus.dev_resp_v_i        = rv;
        bus.dev_resp_header_i   = rhdr;
        bus.dev_resp_critical_i = rcrit;
        bus.resp_ready_and_i    = rrdy;

        s.cmd_v = 0; s.req_rdy = '0; s.resp_v = '0; s.dresp_rdy = 0; s.outst = 0; s.err = 0;
        if (r) begin
            m_rr = 0;
            m_tq.delete();
            m_err = 0;
            stat_q.push_back(s);
            return;
        end

        any = 0; g = 0;
        for (int k = 0; k < N; k++) begin
            if (!any && v[(m_rr + k) % N]) begin
                any = 1;
                g = (m_rr + k) % N;
            end
        end
        full   = (m_tq.size() == MAX);
        accept = any && !full && dready;
        s.cmd_v = any && !full;
        if (accept) s.req_rdy[g] = 1'b1;

        pop = 0; head = 0;
        if (m_tq.size() == 0) begin
            s.dresp_rdy = rv;
        end else begin
            head = m_tq[0];
            if (rv) s.resp_v[head] = 1'b1;
            s.dresp_rdy = rrdy[head];
            pop = rv && rrdy[head];
        end
        s.outst = m_tq.size();
        s.err   = m_err;
        stat_q.push_back(s);

        if (accept) begin
            p.hdr = hdr[g]; p.crit = crit[g];
            cmd_q.push_back(p);
        end
        if (pop) begin
            q.onehot = '0; q.onehot[head] = 1'b1;
            q.hdr = rhdr; q.crit = rcrit;
            rsp_q.push_back(q);
        end

        if (m_tq.size() == 0 && rv) m_err = 1;
        if (pop) void'(m_tq.pop_front());
        if (accept) begin
            m_tq.push_back(g);
            m_rr = (g + 1) % N;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * MAX && m_tq.size() > 0; i++) begin
            step(0, '0, 1, 1, '1);
        end
    endtask

    // Monitor: compares every cycle's status and every observed handshake.
    initial begin
        stat_t s;
        pay_t  p;
        rsp_t  q;
        forever begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("dev_cmd_v", bus.dev_cmd_v_o, s.cmd_v);
                chk("req_ready", bus.req_ready_and_o, s.req_rdy);
                chk("resp_v", bus.resp_v_o, s.resp_v);
                chk("dev_resp_ready", bus.dev_resp_ready_and_o, s.dresp_rdy);
                chk("outstanding", bus.outstanding_o, s.outst);
                chk("error", bus.error_o, s.err);
            end
            if (bus.dev_cmd_v_o && bus.dev_cmd_ready_and_i) begin
                if (cmd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_unexpected: got handshake expected none at %0t", $time);
                end else begin
                    p = cmd_q.pop_front();
                    chk("cmd_header", bus.dev_cmd_header_o, p.hdr);
                    chk("cmd_critical", bus.dev_cmd_critical_o, p.crit);
                end
            end
            if ((|bus.resp_v_o) && bus.dev_resp_v_i && bus.dev_resp_ready_and_o) begin
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL resp_unexpected: got handshake expected none at %0t", $time);
                end else begin
                    q = rsp_q.pop_front();
                    chk("resp_route", bus.resp_v_o, q.onehot);
                    chk("resp_header", bus.resp_header_o, q.hdr);
                    chk("resp_critical", bus.resp_critical_o, q.crit);
                end
            end
        end
    end

    initial begin
        bus.req_header_i = '0; bus.req_critical_i = '0; bus.req_v_i = '0;
        bus.dev_cmd_ready_and_i = 1'b0; bus.dev_resp_header_i = '0;
        bus.dev_resp_critical_i = '0; bus.dev_resp_v_i = 1'b0;
        bus.resp_ready_and_i = '0;

        // reset state
        repeat (2) step(1, '0, 0, 0, '0);

        // round robin with the device responding every cycle
        step(0, 4'hF, 1, 0, 4'hF);
        repeat (5) step(0, 4'hF, 1, 1, 4'hF);
        drain();

        // full stall on requester 2, then one pop reopens the FIFO
        repeat (6) step(0, 4'b0100, 1, 0, 4'hF);
        step(0, 4'b0100, 1, 1, 4'hF);
        step(0, 4'b0100, 1, 0, 4'hF);
        drain();

        // response backpressure with requester 1 at the head
        step(0, 4'b0010, 1, 0, 4'hF);
        repeat (3) step(0, '0, 1, 1, 4'b1101);
        step(0, '0, 1, 1, 4'b0010);
        drain();

        // spurious response while empty; error must stick
        step(0, '0, 1, 1, 4'hF);
        repeat (3) step(0, '0, 1, 0, 4'hF);

        // reset with two commands in flight, then priority restarts at 0
        repeat (2) step(0, 4'b0101, 1, 0, 4'hF);
        repeat (2) step(1, 4'b0101, 1, 1, 4'hF);
        step(0, 4'hF, 1, 0, 4'hF);
        drain();

        // randomized traffic
        step(1, '0, 0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 256) == 0, N'($urandom), ($urandom % 4) != 0,
                 ($urandom % 3) != 0, N'($urandom));
        end
        step(0, '0, 0, 0, '0);

        @(negedge clk);
        #3;
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("resp_queue_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
